// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes, FSM states, legality helpers.
package alu_pkg;

    localparam int unsigned ALU_NOP = 0;
    localparam int unsigned ALU_ADD = 1;
    localparam int unsigned ALU_SUB = 2;
    localparam int unsigned ALU_MUL = 3;
    localparam int unsigned ALU_DIV = 4;
    localparam int unsigned ALU_MOD = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [31:0] op);
        return (op >= ALU_ADD) && (op <= ALU_MOD);
    endfunction

    function automatic logic op_divides(input logic [31:0] op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues screened requests to a combinational ALU, captures the result after a settle
// time and returns it with zero/error flags over a valid/ready response handshake.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OP_W       = 3,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [OP_W-1:0]   i_req_op,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [DATA_W-1:0] o_alu_in2,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_out,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_z,
    output logic              o_rsp_err,
    output logic              o_busy
);

    localparam int unsigned     CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0]   alu_in2_q, alu_in2_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_z_q, rsp_z_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                req_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_z_d    = rsp_z_q;
        rsp_err_d  = rsp_err_q;
        req_ok     = op_legal(32'(i_req_op)) &&
                     !(op_divides(32'(i_req_op)) && (i_req_a == '0));

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    if (req_ok) begin
                        alu_in1_d = i_req_a;
                        alu_in2_d = i_req_b;
                        alu_op_d  = i_req_op;
                        cnt_d     = CNT_INIT;
                        state_d   = WAIT;
                    end else begin
                        rsp_data_d = '0;
                        rsp_z_d    = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_data_d = i_alu_out;
                    rsp_z_d    = (i_alu_out == '0);
                    rsp_err_d  = 1'b0;
                    alu_op_d   = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_z_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_z_q     <= rsp_z_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_busy      = busy_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_alu_in1   = alu_in1_q;
    assign o_alu_in2   = alu_in2_q;
    assign o_alu_op    = alu_op_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_z     = rsp_z_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (settle 1 and 3) share stimulus, each driven by a
// behavioural ALU; responses are checked against a table through per-instance scoreboards.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_ready;

    logic [1:0]  req_ready, rsp_valid, rsp_z, rsp_err, busy;
    logic [15:0] alu_in1 [2];
    logic [15:0] alu_in2 [2];
    logic [15:0] alu_out [2];
    logic [2:0]  alu_op  [2];
    logic [15:0] rsp_data[2];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        z;
        logic        err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        z;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];
    vec_t vecs[14];

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return (b > a) ? (b - a) : 16'd0;
            3'd3:    return p[15:0];
            3'd4:    return (a == 16'd0) ? 16'hFFFF : (b / a);
            3'd5:    return (a == 16'd0) ? 16'hFFFF : (b % a);
            default: return 16'd0;
        endcase
    endfunction

    assign alu_out[0] = alu_fn(alu_op[0], alu_in1[0], alu_in2[0]);
    assign alu_out[1] = alu_fn(alu_op[1], alu_in1[1], alu_in2[1]);

    alu_issue_ctrl #(.DATA_W(16), .OP_W(3), .SETTLE_CYC(1)) u_dut_s1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_alu_in1(alu_in1[0]), .o_alu_in2(alu_in2[0]), .o_alu_op(alu_op[0]),
        .i_alu_out(alu_out[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data[0]), .o_rsp_z(rsp_z[0]), .o_rsp_err(rsp_err[0]),
        .o_busy(busy[0])
    );

    alu_issue_ctrl #(.DATA_W(16), .OP_W(3), .SETTLE_CYC(3)) u_dut_s3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_alu_in1(alu_in1[1]), .o_alu_in2(alu_in2[1]), .o_alu_op(alu_op[1]),
        .i_alu_out(alu_out[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data[1]), .o_rsp_z(rsp_z[1]), .o_rsp_err(rsp_err[1]),
        .o_busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rsp(input int d, input int lat);
        exp_t e;
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: dut%0d got a response, expected none", d);
            return;
        end
        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk($sformatf("dut%0d latency", d), 32'(lat), 32'(e.lat));
        chk($sformatf("dut%0d data", d), 32'(rsp_data[d]), 32'(e.data));
        chk($sformatf("dut%0d z", d), 32'(rsp_z[d]), 32'(e.z));
        chk($sformatf("dut%0d err", d), 32'(rsp_err[d]), 32'(e.err));
    endtask

    task automatic check_idle(input string tag);
        int n;
        n = 0;
        while (req_ready != 2'b11 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'(2'b11));
        chk({tag, " busy"}, 32'(busy), 32'(2'b00));
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(2'b00));
    endtask

    task automatic run_vec(input vec_t v);
        exp_t       e;
        logic [1:0] seen;
        int         held, n, st;
        bit         released, post_chk;
        logic [2:0] xop;

        e.data = v.data;
        e.z    = v.z;
        e.err  = v.err;
        e.lat  = v.err ? 0 : 1;
        sbq0.push_back(e);
        e.lat  = v.err ? 0 : 3;
        sbq1.push_back(e);

        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = (v.hold == 0);
        @(posedge clk); #1;
        // Scramble the request fields: they must be ignored once accepted.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);

        seen = 2'b00; held = 0; released = 1'b0; post_chk = 1'b0; n = 0;
        while ((seen != 2'b11 || (v.hold > 0 && !released) || post_chk) && n < 60) begin
            @(negedge clk);
            if (post_chk) begin
                chk("idle_after_handshake", 32'(req_ready[0]), 32'd1);
                post_chk = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                st  = (d == 0) ? 1 : 3;
                xop = (!v.err && n < st) ? v.op : 3'd0;
                chk($sformatf("dut%0d alu_op n=%0d", d, n), 32'(alu_op[d]), 32'(xop));
                if (!v.err && n < st) begin
                    chk($sformatf("dut%0d alu_in1", d), 32'(alu_in1[d]), 32'(v.a));
                    chk($sformatf("dut%0d alu_in2", d), 32'(alu_in2[d]), 32'(v.b));
                end
                if (!seen[d] && rsp_valid[d]) begin
                    seen[d] = 1'b1;
                    check_rsp(d, n);
                end
            end
            if (v.hold > 0 && seen[0] && !released) begin
                chk("hold data", 32'(rsp_data[0]), 32'(v.data));
                chk("hold valid", 32'(rsp_valid[0]), 32'd1);
                chk("hold req_ready", 32'(req_ready[0]), 32'd0);
                chk("hold busy", 32'(busy[0]), 32'd1);
                held++;
                if (held == v.hold) begin
                    rsp_ready = 1'b1;
                    released  = 1'b1;
                    post_chk  = 1'b1;
                end
            end
            n++;
        end
        if (seen != 2'b11) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_timeout: seen=%b, expected 11", seen);
            if (!seen[0] && sbq0.size() > 0) void'(sbq0.pop_front());
            if (!seen[1] && sbq1.size() > 0) void'(sbq1.pop_front());
        end
        rsp_ready = 1'b1;
        check_idle("post_op");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op    a         b         data      z     err   hold
        vecs[0]  = '{3'd1, 16'd3,    16'd4,    16'd7,    1'b0, 1'b0, 0};
        vecs[1]  = '{3'd2, 16'd5,    16'd5,    16'd0,    1'b1, 1'b0, 0};
        vecs[2]  = '{3'd2, 16'd9,    16'd2,    16'd0,    1'b1, 1'b0, 0};
        vecs[3]  = '{3'd4, 16'd0,    16'd10,   16'd0,    1'b0, 1'b1, 0};
        vecs[4]  = '{3'd5, 16'd0,    16'd10,   16'd0,    1'b0, 1'b1, 0};
        vecs[5]  = '{3'd7, 16'd1,    16'd2,    16'd0,    1'b0, 1'b1, 0};
        vecs[6]  = '{3'd0, 16'd1,    16'd2,    16'd0,    1'b0, 1'b1, 0};
        vecs[7]  = '{3'd6, 16'd1,    16'd2,    16'd0,    1'b0, 1'b1, 0};
        vecs[8]  = '{3'd3, 16'd300,  16'd300,  16'd24464, 1'b0, 1'b0, 5};
        vecs[9]  = '{3'd4, 16'd4,    16'd17,   16'd4,    1'b0, 1'b0, 0};
        vecs[10] = '{3'd5, 16'd4,    16'd17,   16'd1,    1'b0, 1'b0, 0};
        vecs[11] = '{3'd2, 16'd2,    16'd9,    16'd7,    1'b0, 1'b0, 0};
        vecs[12] = '{3'd1, 16'hFFFF, 16'd1,    16'd0,    1'b1, 1'b0, 0};
        vecs[13] = '{3'd3, 16'h0100, 16'h0100, 16'd0,    1'b1, 1'b0, 0};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #3;
        chk("reset req_ready", 32'(req_ready), 32'(2'b11));
        chk("reset busy", 32'(busy), 32'(2'b00));
        chk("reset rsp_valid", 32'(rsp_valid), 32'(2'b00));
        chk("reset rsp_data", 32'(rsp_data[0]), 32'd0);
        chk("reset alu_op", 32'(alu_op[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset while both instances hold a request in WAIT.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd1; req_a = 16'd3; req_b = 16'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_reset busy", 32'(busy), 32'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async dut%0d req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("async dut%0d busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("async dut%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("async dut%0d alu_op", d), 32'(alu_op[d]), 32'd0);
            chk($sformatf("async dut%0d alu_in1", d), 32'(alu_in1[d]), 32'd0);
            chk($sformatf("async dut%0d alu_in2", d), 32'(alu_in2[d]), 32'd0);
            chk($sformatf("async dut%0d rsp_data", d), 32'(rsp_data[d]), 32'd0);
            chk($sformatf("async dut%0d z/err", d), 32'({rsp_z[d], rsp_err[d]}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_vec('{3'd1, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 0});

        chk("scoreboard drained", 32'(sbq0.size() + sbq1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
